// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO registers (shift-add multiplier, restoring divider).
// Define MULDIV_DIVIDE_EN to build the divider; without it div/divu are treated as no-ops.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [5:0]       alu_control,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             stall,
   output logic             busy,
   output logic [WIDTH-1:0] hilo_rdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [5:0] OP_MFHI  = 6'd16;
   localparam logic [5:0] OP_MTHI  = 6'd17;
   localparam logic [5:0] OP_MFLO  = 6'd18;
   localparam logic [5:0] OP_MTLO  = 6'd19;
   localparam logic [5:0] OP_MULT  = 6'd24;
   localparam logic [5:0] OP_MULTU = 6'd25;
   localparam logic [5:0] OP_DIV   = 6'd26;
   localparam logic [5:0] OP_DIVU  = 6'd27;

`ifdef MULDIV_DIVIDE_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
`else
   typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
`endif

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
      return en ? (~v) + WIDTH'(1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
      return en ? (~v) + (2*WIDTH)'(1) : v;
   endfunction

   state_t                 state;
   logic [2*WIDTH-1:0]     acc;
   logic [WIDTH-1:0]       opb;
   logic                   neg_q;
   logic [CW-1:0]          cnt;
   logic signed [WIDTH-1:0] rs_s, rt_s;
   logic                   is_mul, is_divop, is_md, is_mv, is_hl, signed_op, sign_a, sign_b;
   logic [WIDTH-1:0]       mag_a, mag_b;
   logic [WIDTH:0]         mul_sum;
`ifdef MULDIV_DIVIDE_EN
   logic                   neg_r, op_div;
   logic [WIDTH-1:0]       rs_raw;
   logic [WIDTH:0]         div_shift, div_diff;
`endif

   always_comb begin
      rs_s      = $signed(rs_val);
      rt_s      = $signed(rt_val);
      is_mul    = (alu_control == OP_MULT) || (alu_control == OP_MULTU);
`ifdef MULDIV_DIVIDE_EN
      is_divop  = (alu_control == OP_DIV) || (alu_control == OP_DIVU);
`else
      is_divop  = 1'b0;
`endif
      is_md     = is_mul || is_divop;
      is_mv     = (alu_control >= OP_MFHI) && (alu_control <= OP_MTLO);
      is_hl     = is_md || is_mv;
      signed_op = (alu_control == OP_MULT) || (alu_control == OP_DIV);
      sign_a    = signed_op && (rs_s < 0);
      sign_b    = signed_op && (rt_s < 0);
      mag_a     = neg_w(rs_val, sign_a);
      mag_b     = neg_w(rt_val, sign_b);
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
`ifdef MULDIV_DIVIDE_EN
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb};
`endif
   end

   // Only an accepted HL op may touch HI/LO, so any HL op arriving mid-operation is held off.
   assign stall = valid && busy && is_hl;

   always_comb begin
      hilo_rdata = '0;
      if (alu_control == OP_MFHI)      hilo_rdata = hi;
      else if (alu_control == OP_MFLO) hilo_rdata = lo;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (valid && is_md) begin
                  // Low half of acc holds multiplier (MUL) or dividend/quotient shift register (DIV).
                  acc   <= {{WIDTH{1'b0}}, mag_a};
                  opb   <= mag_b;
                  neg_q <= sign_a ^ sign_b;
                  cnt   <= '0;
                  busy  <= 1'b1;
`ifdef MULDIV_DIVIDE_EN
                  neg_r  <= sign_a;
                  rs_raw <= rs_val;
                  op_div <= is_divop;
                  state  <= is_divop ? DIV : MUL;
`else
                  state  <= MUL;
`endif
               end else if (valid && alu_control == OP_MTHI) begin
                  hi <= rs_val;
               end else if (valid && alu_control == OP_MTLO) begin
                  lo <= rs_val;
               end
            end
            MUL: begin
               acc <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= FIX;
            end
`ifdef MULDIV_DIVIDE_EN
            DIV: begin
               acc <= div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= FIX;
            end
`endif
            FIX: begin
`ifdef MULDIV_DIVIDE_EN
               if (op_div) begin
                  if (opb == '0) begin
                     lo <= '1;
                     hi <= rs_raw;
                  end else begin
                     lo <= neg_w(acc[WIDTH-1:0], neg_q);
                     hi <= neg_w(acc[2*WIDTH-1:WIDTH], neg_r);
                  end
               end else
`endif
               begin
                  {hi, lo} <= neg_2w(acc, neg_q);
               end
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: random HI/LO traffic against a plain-arithmetic reference model.
module tb_muldiv_sequencer;
`ifdef MULDIV_DIVIDE_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [5:0]  alu_control;
   logic [31:0] rs_val, rt_val;
   logic        stall, busy;
   logic [31:0] hilo_rdata, hi, lo;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .valid(valid), .alu_control(alu_control),
      .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .busy(busy),
      .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [63:0] res_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] model_hi = '0, model_lo = '0;
   bit abandon = 1'b0;
   logic prev_busy = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference: full-width arithmetic on 64-bit integers, SV truncating division.
   function automatic logic [63:0] model_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      r = '0;
      case (op)
         6'd24: r = sa * sb;
         6'd25: r = ua * ub;
         default: begin
            if (b == 0)        r = {a, 32'hFFFF_FFFF};
            else if (op == 26) r = {32'(sa % sb), 32'(sa / sb)};
            else               r = {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
      return r;
   endfunction

   function automatic bit is_md_op(input logic [5:0] op);
      return (op == 24) || (op == 25) || (DIV_EN && (op == 26 || op == 27));
   endfunction

   task automatic issue_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      if (is_md_op(op)) begin
         r = model_md(op, a, b);
         res_q.push_back(r);
         model_hi = r[63:32];
         model_lo = r[31:0];
      end
      valid = 1'b1; alu_control = op; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      valid = 1'b0; alu_control = 6'd0;
   endtask

   task automatic wait_done(input logic [5:0] op);
      int n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         n++;
      end
      check("busy_len", n, is_md_op(op) ? 64'd33 : 64'd0);
      if (!is_md_op(op)) begin
         check("noop_hi", hi, model_hi);
         check("noop_lo", lo, model_lo);
      end
   endtask

   task automatic do_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      issue_md(op, a, b);
      wait_done(op);
   endtask

   task automatic do_move(input logic [5:0] op, input logic [31:0] a);
      if (op == 17) model_hi = a; else model_lo = a;
      valid = 1'b1; alu_control = op; rs_val = a; rt_val = $urandom;
      @(posedge clk); #1;
      valid = 1'b0; alu_control = 6'd0;
   endtask

   task automatic do_read(input logic [5:0] op);
      bit ok = 1'b0;
      rd_q.push_back(op == 16 ? model_hi : model_lo);
      valid = 1'b1; alu_control = op;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (stall === 1'b0) begin ok = 1'b1; break; end
      end
      if (!ok) check("read_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      valid = 1'b0; alu_control = 6'd0;
   endtask

   function automatic logic [31:0] rand_opnd();
      logic [31:0] c [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
      if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   // Monitor: checks reads when accepted and HI/LO whenever an operation completes.
   always begin
      @(negedge clk);
      if (valid === 1'b1 && (alu_control == 16 || alu_control == 18) && stall === 1'b0) begin
         if (rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
         else check("rdata", {32'h0, hilo_rdata}, {32'h0, rd_q.pop_front()});
      end
      if (prev_busy === 1'b1 && busy === 1'b0) begin
         if (abandon) abandon = 1'b0;
         else if (res_q.size() == 0) check("done_unexpected", 64'd1, 64'd0);
         else check("hilo_result", {hi, lo}, res_q.pop_front());
      end
      prev_busy = busy;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int stall_err;
      logic [5:0] op;
      logic [5:0] ops [9] = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd16, 6'd17, 6'd18, 6'd19, 6'd32};
      rst = 1'b1; valid = 1'b0; alu_control = '0; rs_val = '0; rt_val = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_stall", stall, 0);

      do_md(24, 32'hFFFF_FFFD, 32'd7);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFEB);
      do_read(16);
      do_md(25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);
      do_read(18);
      do_md(26, -32'sd7, 32'd2);
      if (DIV_EN) begin
         check("div_lo", lo, 32'hFFFF_FFFD);
         check("div_hi", hi, 32'hFFFF_FFFF);
      end
      do_md(27, 32'd100, 32'd7);
      if (DIV_EN) begin
         check("divu_lo", lo, 32'd14);
         check("divu_hi", hi, 32'd2);
      end
      do_md(27, 32'd5, 32'd0);
      do_md(26, 32'h8000_0000, 32'hFFFF_FFFF);
      do_md(24, 32'd3, 32'd5);

      // mult 6x7 with an add and a held mflo arriving mid-operation.
      issue_md(24, 32'd6, 32'd7);
      repeat (3) @(posedge clk);
      #1 valid = 1'b1; alu_control = 6'd32; rs_val = 32'd1; rt_val = 32'd2;
      @(negedge clk);
      check("add_busy", busy, 1);
      check("add_stall", stall, 0);
      @(posedge clk); #1;
      rd_q.push_back(32'd42);
      alu_control = 6'd18;
      stall_err = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (stall !== busy) stall_err++;
         if (busy === 1'b0) break;
      end
      check("held_stall_err", stall_err, 0);
      check("held_unstalled", {busy, stall}, 2'b00);
      @(posedge clk); #1 valid = 1'b0; alu_control = 6'd0;

      // Back-to-back: the next op issues in the first idle cycle.
      for (int i = 0; i < 30; i++) begin
         op = ops[$urandom_range(0, 8)];
         case (op)
            24, 25, 26, 27: do_md(op, rand_opnd(), rand_opnd());
            17, 19:         do_move(op, rand_opnd());
            16, 18:         do_read(op);
            default: begin
               valid = 1'b1; alu_control = op; rs_val = $urandom; rt_val = $urandom;
               @(posedge clk); #1 valid = 1'b0; alu_control = 6'd0;
               @(negedge clk);
               check("nonhl_hi", hi, model_hi);
               check("nonhl_lo", lo, model_lo);
            end
         endcase
      end

      // Reset during an operation abandons it.
      issue_md(DIV_EN ? 6'd27 : 6'd25, 32'hDEAD_BEEF, 32'd13);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      abandon = 1'b1;
      res_q.delete();
      model_hi = '0; model_lo = '0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_hi", hi, 0);
      check("midrst_lo", lo, 0);
      check("midrst_stall", stall, 0);
      do_move(19, 32'h1234);
      do_read(18);
      check("mtlo_lo", lo, 32'h1234);
      do_md(24, 32'd6, 32'd7);
      do_read(18);
      repeat (2) @(negedge clk);
      check("q_empty", res_q.size() + rd_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
